// File: rtl/serial_pkg.sv
// Shared types for the bit-serial operand feeder.
// State encoding is a single bit: idle or shifting.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand feeder for the bit-serial adder.
// Emits A/B LSB-first with first/last framing and a carry clear.
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last,
    output logic             adder_clr
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_a_d;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] sh_b_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             accept;
    logic             at_last;

    assign accept  = in_valid && (state_q == IDLE);
    assign at_last = (cnt_q == LAST);

    // Next-state: load on handshake, then shift out WIDTH bits.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_a_d  = in_a;
                    sh_b_d  = in_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
                if (at_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, shift and count registers; reset aborts any stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registers only; IDLE holds the adder carry clear.
    always_comb begin
        in_ready  = (state_q == IDLE);
        ser_valid = (state_q == SHIFT);
        ser_a     = sh_a_q[0];
        ser_b     = sh_b_q[0];
        ser_first = (state_q == SHIFT) && (cnt_q == '0);
        ser_last  = (state_q == SHIFT) && at_last;
        adder_clr = (state_q != SHIFT);
    end

endmodule
